// File: rtl/arb_rr8_hold.sv
// Eight-way round-robin arbiter with a bounded hold time.
// A granted requester keeps the grant while it holds req, but once it has
// held for MAX_HOLD cycles and someone else is waiting, the grant rotates.
// All outputs are registered; req only reaches grant through the next edge.
module arb_rr8_hold #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_id,
  output logic       grant_valid,
  output logic       grant_new
);

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state_reg, state_next;
  logic [2:0] ptr_reg, ptr_next;
  logic [3:0] hold_cnt_reg, hold_cnt_next;
  logic [7:0] grant_reg, grant_next;
  logic [2:0] id_reg, id_next;
  logic       valid_reg, valid_next;
  logic       new_reg, new_next;

  // Search inputs: from IDLE we scan all requests from ptr; from BUSY we
  // scan everyone except the current holder, starting just past it.
  logic [2:0] next_start;
  logic [2:0] search_start;
  logic [7:0] cand;
  logic [2:0] win_id;
  logic       win_any;
  logic [7:0] win_onehot;

  // First set bit of c at or after s, wrapping mod 8. Scanning downwards
  // lets the last hit (the closest one to s) win without a found flag.
  function automatic logic [2:0] pick(input logic [7:0] c, input logic [2:0] s);
    logic [2:0] r;
    logic [2:0] idx;
    r = s;
    for (int i = 7; i >= 0; i--) begin
      idx = s + 3'(i);
      if (c[idx]) r = idx;
    end
    return r;
  endfunction

  assign next_start   = id_reg + 3'd1;
  assign search_start = (state_reg == IDLE) ? ptr_reg : next_start;
  assign cand         = (state_reg == IDLE) ? req : (req & ~grant_reg);
  assign win_any      = |cand;
  assign win_id       = pick(cand, search_start);

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_onehot
      assign win_onehot[gi] = (win_id == 3'(gi));
    end
  endgenerate

  // Next-state and next-output logic for the IDLE/BUSY controller.
  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    hold_cnt_next = hold_cnt_reg;
    grant_next    = grant_reg;
    id_next       = id_reg;
    valid_next    = valid_reg;
    new_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (win_any) begin
          state_next    = BUSY;
          grant_next    = win_onehot;
          id_next       = win_id;
          valid_next    = 1'b1;
          new_next      = 1'b1;
          hold_cnt_next = 4'd1;
        end
      end
      BUSY: begin
        if (!req[id_reg]) begin
          // Release: move the pointer past the holder and hand over in the
          // same edge if anyone else is asking.
          ptr_next = next_start;
          if (win_any) begin
            grant_next    = win_onehot;
            id_next       = win_id;
            new_next      = 1'b1;
            hold_cnt_next = 4'd1;
          end else begin
            state_next    = IDLE;
            grant_next    = 8'h00;
            id_next       = 3'd0;
            valid_next    = 1'b0;
            hold_cnt_next = 4'd0;
          end
        end else if ((hold_cnt_reg == HOLD_MAX) && win_any) begin
          // Preemption: holder used up its budget and others are waiting.
          ptr_next      = next_start;
          grant_next    = win_onehot;
          id_next       = win_id;
          new_next      = 1'b1;
          hold_cnt_next = 4'd1;
        end else if (hold_cnt_reg < HOLD_MAX) begin
          hold_cnt_next = hold_cnt_reg + 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      ptr_reg      <= 3'd0;
      hold_cnt_reg <= 4'd0;
      grant_reg    <= 8'h00;
      id_reg       <= 3'd0;
      valid_reg    <= 1'b0;
      new_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      hold_cnt_reg <= hold_cnt_next;
      grant_reg    <= grant_next;
      id_reg       <= id_next;
      valid_reg    <= valid_next;
      new_reg      <= new_next;
    end
  end

  assign grant       = grant_reg;
  assign grant_id    = id_reg;
  assign grant_valid = valid_reg;
  assign grant_new   = new_reg;

endmodule
